// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - CPU data-memory port bundle between cpu and data_bus_responder
interface data_bus_responder_if;
  logic [15:0] addr_bus;
  logic [15:0] wdata;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] rdata;

  modport master (
    output addr_bus, wdata, ram_read, ram_write,
    input  rdata
  );

  modport slave (
    input  addr_bus, wdata, ram_read, ram_write,
    output rdata
  );
endinterface

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - zero-wait data RAM plus LED, timer and 8N1 UART TX with FIFO
module data_bus_responder #(
  parameter int RAM_AW       = 12,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  data_bus_responder_if.slave   bus,
  output logic [7:0]            leds,
  output logic                  uart_tx
);
  localparam logic [15:0] A_LED   = 16'hFF00;
  localparam logic [15:0] A_TIMER = 16'hFF01;
  localparam logic [15:0] A_TXDAT = 16'hFF02;
  localparam logic [15:0] A_STAT  = 16'hFF03;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0]      r_ram [2**RAM_AW];
  logic [7:0]       r_leds;
  logic [15:0]      r_timer;
  logic             r_tmr_ovf;
  logic             r_tx_drop;
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx;

  logic        w_ram_sel;
  logic        w_wr_ram, w_wr_led, w_wr_timer, w_wr_txdat, w_wr_stat;
  logic [PW:0] w_count;
  logic        w_full, w_empty, w_pop, w_push, w_drop, w_busy, w_wrap;
  logic [15:0] w_stat;

  assign w_ram_sel  = (bus.addr_bus >> RAM_AW) == 16'd0;
  assign w_wr_ram   = bus.ram_write && w_ram_sel;
  assign w_wr_led   = bus.ram_write && (bus.addr_bus == A_LED);
  assign w_wr_timer = bus.ram_write && (bus.addr_bus == A_TIMER);
  assign w_wr_txdat = bus.ram_write && (bus.addr_bus == A_TXDAT);
  assign w_wr_stat  = bus.ram_write && (bus.addr_bus == A_STAT);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = w_count == (PW+1)'(FIFO_DEPTH);
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_busy  = r_state != S_IDLE;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_push  = w_wr_txdat && (!w_full || w_pop);
  assign w_drop  = w_wr_txdat && !w_push;
  assign w_wrap  = !w_wr_timer && (r_timer == 16'hFFFF);
  assign w_stat  = {11'd0, r_tx_drop, r_tmr_ovf, w_busy, w_empty, w_full};

  assign leds    = r_leds;
  assign uart_tx = r_tx;

  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.ram_read) begin
      if (w_ram_sel) begin
        bus.rdata = r_ram[bus.addr_bus[RAM_AW-1:0]];
      end else begin
        case (bus.addr_bus)
          A_LED:   bus.rdata = {8'h00, r_leds};
          A_TIMER: bus.rdata = r_timer;
          A_STAT:  bus.rdata = w_stat;
          default: bus.rdata = 16'h0000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[bus.addr_bus[RAM_AW-1:0]] <= bus.wdata;
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds    <= 8'h00;
      r_timer   <= 16'h0000;
      r_tmr_ovf <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_wr_led) r_leds <= bus.wdata[7:0];
      r_timer <= w_wr_timer ? bus.wdata : r_timer + 16'd1;
      if (w_wrap) r_tmr_ovf <= 1'b1;
      else if (w_wr_stat && bus.wdata[3]) r_tmr_ovf <= 1'b0;
      if (w_drop) r_tx_drop <= 1'b1;
      else if (w_wr_stat && bus.wdata[4]) r_tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_cnt     <= '0;
      r_tx      <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= r_fifo[r_rd_ptr[PW-1:0]];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - directed bench with UART frame scoreboard for data_bus_responder
module tb_data_bus_responder;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] leds;
  logic       uart_tx;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] sb[$];
  logic [15:0] rd;

  data_bus_responder_if bus_if ();

  data_bus_responder #(.RAM_AW(12), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .leds    (leds),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_if.addr_bus  = a;
    bus_if.wdata     = d;
    bus_if.ram_write = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ram_write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_if.addr_bus = a;
    bus_if.ram_read = 1'b1;
    #1;
    d = bus_if.rdata;
    bus_if.ram_read = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (CPB * 2) @(posedge clk);
    check(tag, 16'(sb.size()), 16'd0);
  endtask

  // Receiver: on a falling line, sample the middle of each bit cell; drop frames cut by reset.
  logic prev_tx = 1'b1;
  always begin
    @(negedge clk);
    if (!rst && prev_tx === 1'b1 && uart_tx === 1'b0) begin
      logic [7:0] b;
      logic       aborted;
      logic       stop_bit;
      aborted = 1'b0;
      b = 8'h00;
      for (int k = 1; k <= 9 * CPB + 1; k++) begin
        @(negedge clk);
        if (rst) aborted = 1'b1;
        if (k > CPB && k < 9 * CPB && (k % CPB) == 1) b[(k / CPB) - 1] = uart_tx;
        if (k == 9 * CPB + 1) stop_bit = uart_tx;
      end
      if (!aborted) begin
        check("uart_stop", {15'd0, stop_bit}, 16'd1);
        if (sb.size() == 0) begin
          check("uart_unexpected_frame", {8'h00, b}, 16'hFFFF);
        end else begin
          check("uart_byte", {8'h00, b}, {8'h00, sb.pop_front()});
        end
      end
    end
    prev_tx = uart_tx;
  end

  initial begin
    int busy;
    bus_if.addr_bus  = 16'h0000;
    bus_if.wdata     = 16'h0000;
    bus_if.ram_read  = 1'b0;
    bus_if.ram_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", {8'h00, leds}, 16'h0000);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    bus_read(16'hFF03, rd); check("rst_stat", rd, 16'h0002);
    bus_read(16'hFF01, rd); check("rst_timer", rd, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // RAM
    bus_write(16'h0011, 16'hBEEF);
    bus_write(16'h0010, 16'h1234);
    bus_read(16'h0010, rd); check("ram_rd_0010", rd, 16'h1234);
    bus_read(16'h0011, rd); check("ram_rd_0011", rd, 16'hBEEF);
    @(negedge clk);
    bus_if.addr_bus  = 16'h0010;
    bus_if.wdata     = 16'h9999;
    bus_if.ram_read  = 1'b1;
    bus_if.ram_write = 1'b1;
    #1;
    check("ram_rw_prewrite", bus_if.rdata, 16'h1234);
    @(posedge clk);
    #1;
    bus_if.ram_write = 1'b0;
    bus_if.ram_read  = 1'b0;
    #1;
    check("rdata_idle_zero", bus_if.rdata, 16'h0000);
    bus_read(16'h0010, rd); check("ram_rw_postwrite", rd, 16'h9999);
    bus_read(16'h0FFF, rd);
    bus_write(16'h0FFF, 16'h0F0F);
    bus_read(16'h0FFF, rd); check("ram_top_word", rd, 16'h0F0F);

    // LED and unmapped
    bus_write(16'hFF00, 16'hABCD);
    check("led_port", {8'h00, leds}, 16'h00CD);
    bus_read(16'hFF00, rd); check("led_rd", rd, 16'h00CD);
    bus_write(16'h8000, 16'h5555);
    bus_read(16'h8000, rd); check("unmapped_rd", rd, 16'h0000);
    bus_read(16'h1000, rd); check("unmapped_above_ram", rd, 16'h0000);
    check("unmapped_led_kept", {8'h00, leds}, 16'h00CD);
    bus_read(16'hFF02, rd); check("txdat_rd", rd, 16'h0000);

    // Timer wrap and sticky overflow
    bus_write(16'hFF01, 16'hFFFE);
    @(posedge clk);
    @(posedge clk);
    bus_read(16'hFF01, rd); check("timer_wrap", rd, 16'h0000);
    bus_read(16'hFF03, rd); check("stat_ovf_set", rd, 16'h000A);
    bus_write(16'hFF03, 16'h0008);
    bus_read(16'hFF03, rd); check("stat_ovf_clr", rd, 16'h0002);

    // Single UART frame: busy for exactly 10 bit times
    sb.push_back(8'h55);
    bus_write(16'hFF02, 16'h0055);
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      bus_read(16'hFF03, rd);
      if (rd[2]) busy++;
    end
    check("tx_busy_cycles", 16'(busy), 16'(10 * CPB));
    wait_drain("frame_55_drained");

    // FIFO overflow: first byte leaves early, 5th fills, 6th dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back(8'h10 + 8'(i));
      bus_write(16'hFF02, 16'h0010 + 16'(i));
    end
    bus_read(16'hFF03, rd); check("stat_full_drop", rd, 16'h0015);
    wait_drain("fifo_frames_drained");
    bus_read(16'hFF03, rd); check("stat_drop_kept", rd, 16'h0012);
    bus_write(16'hFF03, 16'h0010);
    bus_read(16'hFF03, rd); check("stat_drop_clr", rd, 16'h0002);

    // Reset mid-frame
    bus_write(16'hFF02, 16'h00A5);
    bus_write(16'hFF02, 16'h003C);
    repeat (CPB * 4 + 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("rst_mid_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_mid_leds", {8'h00, leds}, 16'h0000);
    bus_read(16'hFF03, rd); check("rst_mid_stat", rd, 16'h0002);
    bus_read(16'hFF01, rd); check("rst_mid_timer", rd, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("post_rst_idle", {15'd0, uart_tx}, 16'd1);
    check("post_rst_no_frames", 16'(sb.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
